// File: rtl/rv32i_mem_pkg.sv
// Shared types and constants for the rv32i data-memory responder.
// Contents: FSM state enum, latency counter width, default tohost address,
// latched request payload struct and a word-index width helper.
// Optional feature macro used by consumers: DMEM_TOHOST_EN.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Wide enough for LATENCY up to 15.
  localparam int unsigned LAT_CNT_W = 4;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

  // Request payload captured at accept.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

  // Word-index width for a power-of-two array depth.
  function automatic int unsigned word_idx_w(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/rv32i_dmem_responder_if.sv
// Valid/ready request and response channels between the core LSU (master)
// and the data-memory responder (slave).
//   req_valid/req_ready, req_we, req_addr, req_wdata, req_wstrb : request
//   resp_valid/resp_ready, resp_rdata, resp_err                 : response
interface rv32i_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_bytewise_ram.sv
// Single-port word array with per-byte write enables.
// Writes are synchronous; the read port is combinational so the owner can
// capture the word in the same edge that commits an access.
//   clk       : clock
//   be_i      : byte-lane write enables (bit i -> bits [8i+7:8i])
//   addr_i    : word index
//   wdata_i   : write data
//   rdata_o   : word at addr_i (combinational)
module dmem_bytewise_ram
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                               clk,
  input  logic [3:0]                         be_i,
  input  logic [word_idx_w(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                        wdata_i,
  output logic [31:0]                        rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Byte-lane writes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the rv32i core LSU: accepts one request at a
// time, responds a fixed LATENCY cycles later, faults misaligned and
// out-of-range accesses.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   bus       : request/response channels (slave side)
//   sim_done  : sticky completion flag       (DMEM_TOHOST_EN only)
//   sim_code  : completion code wdata[31:1]  (DMEM_TOHOST_EN only)
// Optional feature macro: DMEM_TOHOST_EN adds a tohost completion register
// at TOHOST_ADDR, decoded ahead of the array range check.
module rv32i_dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
`ifdef DMEM_TOHOST_EN
  ,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  rv32i_dmem_responder_if.slave   bus
`ifdef DMEM_TOHOST_EN
  ,
  output logic                    sim_done,
  output logic [30:0]             sim_code
`endif
);

  localparam int unsigned IDX_W = word_idx_w(DEPTH_WORDS);

  dmem_state_e          state_q;
  logic [LAT_CNT_W-1:0] cnt_q;
  dmem_req_t            req_q;
  logic                 resp_valid_q;
  logic [31:0]          resp_rdata_q;
  logic                 resp_err_q;

  dmem_req_t            cur_c;
  logic                 accept_c;
  logic                 commit_c;
  logic                 misalign_c;
  logic                 oob_c;
  logic                 fault_c;
  logic                 array_wr_c;
  logic [3:0]           ram_be_c;
  logic [31:0]          ram_rdata_c;
  logic [31:0]          load_data_c;

`ifdef DMEM_TOHOST_EN
  logic                 is_tohost_c;
  logic [31:0]          tohost_q;
  logic                 sim_done_q;
  logic [30:0]          sim_code_q;
`endif

  assign bus.req_ready  = (state_q == ST_IDLE) & rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  assign accept_c = bus.req_valid & bus.req_ready;

  // With LATENCY==1 the commit happens on the accept edge itself, before
  // req_q is loaded, so the live bus payload is used while in IDLE.
  always_comb begin
    cur_c = req_q;
    if (state_q == ST_IDLE) begin
      cur_c.we    = bus.req_we;
      cur_c.addr  = bus.req_addr;
      cur_c.wdata = bus.req_wdata;
      cur_c.wstrb = bus.req_wstrb;
    end
  end

  assign commit_c = rst & (((state_q == ST_IDLE) & accept_c & (LATENCY == 1)) |
                           ((state_q == ST_WAIT) & (cnt_q == '0)));

  assign misalign_c = |cur_c.addr[1:0];
  assign oob_c      = cur_c.addr[31:2] >= 30'(DEPTH_WORDS);

`ifdef DMEM_TOHOST_EN
  assign is_tohost_c = (cur_c.addr == TOHOST_ADDR);
  assign fault_c     = misalign_c | (oob_c & ~is_tohost_c);
  assign array_wr_c  = commit_c & cur_c.we & ~fault_c & ~is_tohost_c;
  assign load_data_c = is_tohost_c ? tohost_q : ram_rdata_c;
  assign sim_done    = sim_done_q;
  assign sim_code    = sim_code_q;
`else
  assign fault_c     = misalign_c | oob_c;
  assign array_wr_c  = commit_c & cur_c.we & ~fault_c;
  assign load_data_c = ram_rdata_c;
`endif

  assign ram_be_c = array_wr_c ? cur_c.wstrb : 4'b0000;

  dmem_bytewise_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .be_i    (ram_be_c),
    .addr_i  (cur_c.addr[IDX_W+1:2]),
    .wdata_i (cur_c.wdata),
    .rdata_o (ram_rdata_c)
  );

  // Request FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef DMEM_TOHOST_EN
      tohost_q     <= '0;
      sim_done_q   <= 1'b0;
      sim_code_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            req_q <= cur_c;
            if (LATENCY == 1) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= LAT_CNT_W'(LATENCY - 2);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_RESP;
          else             cnt_q   <= cnt_q - LAT_CNT_W'(1);
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (commit_c) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= fault_c;
        resp_rdata_q <= (fault_c | cur_c.we) ? 32'h0 : load_data_c;
      end

`ifdef DMEM_TOHOST_EN
      // tohost register: byte-merged like memory; a full-word store with
      // bit 0 set latches completion.
      if (commit_c & cur_c.we & ~fault_c & is_tohost_c) begin
        for (int b = 0; b < 4; b++) begin
          if (cur_c.wstrb[b]) tohost_q[8*b +: 8] <= cur_c.wdata[8*b +: 8];
        end
        if ((cur_c.wstrb == 4'hF) & cur_c.wdata[0]) begin
          sim_done_q <= 1'b1;
          sim_code_q <= cur_c.wdata[31:1];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed self-checking bench for rv32i_dmem_responder (LATENCY=2,
// DEPTH_WORDS=1024). Define DMEM_TOHOST_EN to also exercise tohost.
module tb_rv32i_dmem_responder;

  localparam int unsigned DEPTH = 1024;

  logic clk;
  logic rst;
`ifdef DMEM_TOHOST_EN
  logic        sim_done;
  logic [30:0] sim_code;
`endif

  int n_checks;
  int n_errors;

  rv32i_dmem_responder_if bus ();

  rv32i_dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef DMEM_TOHOST_EN
    ,
    .sim_done (sim_done),
    .sim_code (sim_code)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, 2-cycle latency check, optional stall,
  // response handshake. Payload is scrambled right after accept.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int hold);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " accept"}, 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom());
    bus.req_addr  = $urandom();
    bus.req_wdata = $urandom();
    bus.req_wstrb = 4'($urandom());
    chk({tag, " early"}, 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, " valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, " rdata"}, bus.resp_rdata, exp_rdata);
    chk({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
    chk({tag, " busy"}, 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, " hold rdata"}, bus.resp_rdata, exp_rdata);
      chk({tag, " hold ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({tag, " drop"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, " ready back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
    bus.resp_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(bus.resp_valid), 32'd0);
    chk("rst rdata", bus.resp_rdata, 32'h0);
    chk("rst err", 32'(bus.resp_err), 32'd0);
    chk("rst ready", 32'(bus.req_ready), 32'd0);
`ifdef DMEM_TOHOST_EN
    chk("rst sim_done", 32'(sim_done), 32'd0);
    chk("rst sim_code", 32'(sim_code), 32'd0);
`endif
    rst = 1'b1;
    #1;
    chk("ready after rst", 32'(bus.req_ready), 32'd1);

    // Full-word store and readback.
    xact("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
    xact("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Byte-lane store.
    xact("stb10", 1'b1, 32'h10, 32'h0000_0055, 4'b0001, 32'h0, 1'b0, 0);
    xact("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BE55, 1'b0, 0);

    // wstrb=0 store is a no-op.
    xact("st0", 1'b1, 32'h10, 32'h1111_1111, 4'b0000, 32'h0, 1'b0, 0);
    xact("ld10c", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BE55, 1'b0, 0);

    // Faults: misaligned, first out-of-range word, faulting store.
    xact("ld13", 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    xact("ldoob", 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 32'h0, 1'b1, 0);
    xact("stmis", 1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
    xact("ld10d", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BE55, 1'b0, 0);

    // Last in-range word and a stalled response.
    xact("sttop", 1'b1, 32'(4 * DEPTH - 4), 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0, 0);
    xact("ldtop", 1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'h0, 32'hA5A5_0F0F, 1'b0, 5);

    // Reset while a store to 0x20 is in WAIT.
    xact("st20", 1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_wstrb = 4'hF;
    chk("mid ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("mid wait", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid rst valid", 32'(bus.resp_valid), 32'd0);
    chk("mid rst err", 32'(bus.resp_err), 32'd0);
    chk("mid rst ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid ready back", 32'(bus.req_ready), 32'd1);
    chk("mid no resp", 32'(bus.resp_valid), 32'd0);
    xact("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0);

`ifdef DMEM_TOHOST_EN
    xact("th1", 1'b1, 32'h0000_1000, 32'h0000_0001, 4'hF, 32'h0, 1'b0, 0);
    chk("th1 done", 32'(sim_done), 32'd1);
    chk("th1 code", 32'(sim_code), 32'd0);
    xact("th7", 1'b1, 32'h0000_1000, 32'h0000_0007, 4'hF, 32'h0, 1'b0, 0);
    chk("th7 done", 32'(sim_done), 32'd1);
    chk("th7 code", 32'(sim_code), 32'd3);
    xact("thld", 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h0000_0007, 1'b0, 0);
`else
    xact("thoob", 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32i_dmem_responder.md
Name: rv32i_dmem_responder

Overview:
- Data-memory responder that services load/store requests from the rv32i_core load/store unit over a valid/ready request channel and a valid/ready response channel.
- Fixed, parameterised response latency models wait-state memory; rejects misaligned and out-of-range accesses with an error flag.
- Sits beside the core inside the simulation top; it is the memory end of the core's data interface.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the backing array (power of two).
- LATENCY, 2, cycles from request accept to resp_valid; legal range 1..15.
- TOHOST_ADDR, 32'h0000_1000, byte address of the completion register (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  store byte enables; bit i selects bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  access fault.
- sim_done  out  1  completion flag; this port exists only with DMEM_TOHOST_EN.
- sim_code  out  31  completion code; this port exists only with DMEM_TOHOST_EN.

Behaviour:
- Reset: any rising edge with rst=0 sets state IDLE, resp_valid=0, resp_rdata=0, resp_err=0. req_ready is forced 0 while rst=0. Array contents are not cleared.
- Reset mid-operation: an in-flight request is dropped with no response. A store not yet committed is not written.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) & rst. Accept = req_valid & req_ready at a rising edge. On accept, addr/we/wdata/wstrb are latched.
- IDLE to RESP on accept if LATENCY==1. Otherwise IDLE to WAIT, with counter loaded to LATENCY-2.
- WAIT: if the counter is 0, go to RESP; otherwise decrement.
- Timing: resp_valid is high starting exactly LATENCY cycles after the accept edge.
- Commit on the edge entering RESP:
  - Fault check: fault = addr[1:0]!=0 OR addr[31:2] >= DEPTH_WORDS.
  - Fault: resp_err=1, resp_rdata=0, no write.
  - Load: resp_rdata = the array word at addr[31:2], reflecting all earlier committed stores.
  - Store: only enabled bytes are written; resp_rdata=0. wstrb=0 is a legal no-op with err=0.
- RESP holds resp_valid, resp_rdata and resp_err stable until resp_ready=1. On that edge the FSM returns to IDLE, resp_valid drops, and req_ready rises the next cycle. There are no back-to-back accepts in the same cycle as a response handshake.
- req_valid is ignored outside IDLE. The requester must hold its payload stable only until accept.

Optional Feature:
- Macro: DMEM_TOHOST_EN.
- With the macro defined:
  - A non-faulting store to TOHOST_ADDR with wstrb=4'hF and wdata[0]=1 sets sim_done=1 (sticky until reset) and sim_code=wdata[31:1].
  - That word is not written to the array. Loads from TOHOST_ADDR return the last value stored there.
  - sim_done and sim_code reset to 0.
- Without the macro: no extra ports or logic; TOHOST_ADDR is an ordinary array address, faulting if out of range.

Decomposition:
- Package rv32i_mem_pkg holds:
  - the FSM state enumeration;
  - the LATENCY counter width constant (4 bits);
  - the default TOHOST_ADDR;
  - the word-index helper width, $clog2(DEPTH_WORDS).
- One sub-module is natural: dmem_bytewise_ram, a synchronous single-port array with 4 byte-lane write enables. The FSM, fault check and tohost logic stay in the top module.

Test Plan:
- Store 32'hDEAD_BEEF at 0x10 with wstrb=F, then load 0x10 (LATENCY=2) -> resp_valid rises exactly 2 cycles after each accept; load returns 32'hDEAD_BEEF, err=0.
- Store 32'h0000_0055 at 0x10 with wstrb=4'b0001, then load 0x10 -> 32'hDEAD_BE55.
- Load 0x13 (misaligned), then load 4*DEPTH_WORDS (out of range) -> err=1, rdata=0 for both; a following load of 0x10 is unaffected.
- Hold resp_ready=0 for 5 cycles -> resp_valid and rdata stay stable and req_ready stays 0; on resp_ready=1, req_ready returns the next cycle.
- Drive rst=0 in the WAIT state of a store to 0x20 -> no response; after reset, a load of 0x20 returns its old value and resp_valid/resp_err are 0.
- With DMEM_TOHOST_EN, store 32'h0000_0001 to TOHOST_ADDR -> sim_done=1 and sim_code=0 one response later; a store of 32'h0000_0007 gives sim_code=3.
